// File: rtl/pbvi_belief_update.sv
// Two-state POMDP belief update: predict through T(s'|s,a), weight by O(o|s',a),
// then normalise with a 16-iteration restoring divider. Beliefs are unsigned Q1.15.
module pbvi_belief_update #(
   parameter int W     = 16,
   parameter int FRAC  = 15,
   parameter int N_ACT = 4,
   parameter int N_OBS = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [1:0]                           action,
   input  logic [1:0]                           observation,
   input  logic [N_ACT-1:0][1:0][1:0][W-1:0]      trans,
   input  logic [N_ACT-1:0][1:0][N_OBS-1:0][W-1:0] obs_prob,
   input  logic                                 init_load,
   input  logic [W-1:0]                         init_b0,
   output logic [1:0][W-1:0]                    belief,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err_zero
);

   localparam logic [W-1:0] ONE  = W'(1) << FRAC;
   localparam logic [W-1:0] HALF = ONE >> 1;

   typedef enum logic [2:0] {IDLE, PREDICT, CORRECT, DIVIDE, FINISH} state_t;

   state_t state, state_n;

   function automatic logic [2*W:0] mulq(input logic [W-1:0] a, input logic [W:0] b);
      return {{(W+1){1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic logic [W-1:0] sat_one(input logic [W-1:0] x);
      return (x > ONE) ? ONE : x;
   endfunction

   logic [1:0]   act_q, obs_q;
   logic [W:0]   pred0, pred1;
   logic [2*W:0] psum0, psum1, uprod0, uprod1;
   logic [W:0]   un0_n, un1_n;
   logic [W+1:0] norm_n, norm_q, rem;
   logic [W-1:0] dvd, quo;
   logic [3:0]   cnt;
   logic [W+2:0] rshift, rdiff;
   logic         rge;
   logic         unused_bits;

   assign psum0  = mulq(trans[act_q][0][0], {1'b0, belief[0]}) + mulq(trans[act_q][1][0], {1'b0, belief[1]});
   assign psum1  = mulq(trans[act_q][0][1], {1'b0, belief[0]}) + mulq(trans[act_q][1][1], {1'b0, belief[1]});
   assign uprod0 = mulq(obs_prob[act_q][0][obs_q], pred0);
   assign uprod1 = mulq(obs_prob[act_q][1][obs_q], pred1);
   assign un0_n  = uprod0[FRAC+W:FRAC];
   assign un1_n  = uprod1[FRAC+W:FRAC];
   assign norm_n = {1'b0, un0_n} + {1'b0, un1_n};

   // Remainder stays below the divisor, so one extra bit covers the shifted compare.
   assign rshift = {rem, dvd[W-1]};
   assign rdiff  = rshift - {1'b0, norm_q};
   assign rge    = (rshift >= {1'b0, norm_q});

   assign unused_bits = ^{psum0[2*W], psum0[FRAC-1:0], psum1[2*W], psum1[FRAC-1:0],
                          uprod0[2*W], uprod0[FRAC-1:0], uprod1[2*W], uprod1[FRAC-1:0], rdiff[W+2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (!init_load && start) state_n = PREDICT;
         PREDICT: state_n = CORRECT;
         CORRECT: state_n = (norm_n == '0) ? FINISH : DIVIDE;
         DIVIDE:  if (cnt == 4'd15) state_n = FINISH;
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         belief   <= {HALF, HALF};
         busy     <= 1'b0;
         done     <= 1'b0;
         err_zero <= 1'b0;
         act_q    <= '0;
         obs_q    <= '0;
         pred0    <= '0;
         pred1    <= '0;
         norm_q   <= '0;
         rem      <= '0;
         dvd      <= '0;
         quo      <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (init_load) begin
                  belief[0] <= sat_one(init_b0);
                  belief[1] <= ONE - sat_one(init_b0);
               end else if (start) begin
                  act_q    <= action;
                  obs_q    <= observation;
                  err_zero <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            PREDICT: begin
               pred0 <= psum0[FRAC+W:FRAC];
               pred1 <= psum1[FRAC+W:FRAC];
            end
            CORRECT: begin
               if (norm_n == '0) begin
                  err_zero <= 1'b1;
               end else begin
                  // Dividend un0<<FRAC: upper half seeds the remainder, un0[0] is the next bit in.
                  rem    <= {2'b00, un0_n[W:1]};
                  dvd    <= {un0_n[0], {FRAC{1'b0}}};
                  norm_q <= norm_n;
                  quo    <= '0;
                  cnt    <= '0;
               end
            end
            DIVIDE: begin
               rem <= rge ? rdiff[W+1:0] : rshift[W+1:0];
               dvd <= {dvd[W-2:0], 1'b0};
               quo <= {quo[W-2:0], rge};
               cnt <= cnt + 4'd1;
            end
            FINISH: begin
               if (!err_zero) begin
                  belief[0] <= sat_one(quo);
                  belief[1] <= ONE - sat_one(quo);
               end
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pbvi_belief_update.sv
// Scoreboard bench for pbvi_belief_update: directed updates with hand-computed beliefs,
// latency, error flag, busy protection, init priority and mid-operation reset.
module tb_pbvi_belief_update;

   logic                         clk = 1'b0;
   logic                         rst_n = 1'b0;
   logic                         start = 1'b0;
   logic [1:0]                   action = '0;
   logic [1:0]                   observation = '0;
   logic [3:0][1:0][1:0][15:0]   trans;
   logic [3:0][1:0][3:0][15:0]   obs_prob;
   logic                         init_load = 1'b0;
   logic [15:0]                  init_b0 = '0;
   logic [1:0][15:0]             belief;
   logic                         busy, done, err_zero;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] b0;
      logic [15:0] b1;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   exp_t expq[$];

   pbvi_belief_update #(.W(16), .FRAC(15), .N_ACT(4), .N_OBS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .action(action), .observation(observation),
      .trans(trans), .obs_prob(obs_prob), .init_load(init_load), .init_b0(init_b0),
      .belief(belief), .busy(busy), .done(done), .err_zero(err_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (expq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = expq.pop_front();
               chk("belief", {belief[1], belief[0]}, {e.b1, e.b0});
               chk("err_zero", {31'd0, err_zero}, {31'd0, e.err});
               chk("latency", cyc - e.t0, e.lat);
            end
         end
      end
   endtask

   // Caller is positioned at a negedge; start is sampled at the following posedge.
   task automatic issue(input logic [1:0] a, input logic [1:0] o, input logic push,
                        input logic [15:0] eb0, input logic [15:0] eb1,
                        input logic eerr, input int elat);
      exp_t e;
      action = a;
      observation = o;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.b0 = eb0; e.b1 = eb1; e.err = eerr; e.lat = elat; e.t0 = cyc;
         expq.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 60);
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      trans = '0;
      obs_prob = '0;
      trans[0][0][0] = 16'h8000; trans[0][1][1] = 16'h8000;
      trans[1][0][1] = 16'h8000; trans[1][1][0] = 16'h8000;
      trans[2][0][0] = 16'h6000; trans[2][0][1] = 16'h2000;
      trans[2][1][0] = 16'h2000; trans[2][1][1] = 16'h6000;
      obs_prob[0][0][0] = 16'h6000; obs_prob[0][1][0] = 16'h2000;
      obs_prob[1][0][2] = 16'h4000; obs_prob[1][1][2] = 16'h4000;
      obs_prob[2][0][1] = 16'h2000; obs_prob[2][1][1] = 16'h4000;

      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_belief", {belief[1], belief[0]}, 32'h4000_4000);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err_zero}, 32'd0);
      rst_n = 1'b1;

      // Basic update, identity transition
      @(negedge clk);
      issue(2'd0, 2'd0, 1'b1, 16'h6000, 16'h2000, 1'b0, 19);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_done();

      // Same update again, disturbed during DIVIDE
      @(negedge clk);
      issue(2'd0, 2'd0, 1'b1, 16'h7333, 16'h0CCD, 1'b0, 19);
      repeat (6) @(negedge clk);
      start = 1'b1; init_load = 1'b1; init_b0 = 16'h1234; action = 2'd1; observation = 2'd3;
      @(negedge clk);
      start = 1'b0; init_load = 1'b0;
      wait_done();

      // Transition swap
      @(negedge clk);
      init_load = 1'b1; init_b0 = 16'h8000;
      @(posedge clk); #1;
      init_load = 1'b0;
      chk("init_load", {belief[1], belief[0]}, 32'h0000_8000);
      @(negedge clk);
      issue(2'd1, 2'd2, 1'b1, 16'h0000, 16'h8000, 1'b0, 19);
      wait_done();

      // Zero normaliser, then a valid start clears err_zero
      @(negedge clk);
      issue(2'd1, 2'd3, 1'b1, 16'h0000, 16'h8000, 1'b1, 3);
      wait_done();
      repeat (3) @(negedge clk);
      chk("err_zero_hold", {31'd0, err_zero}, 32'd1);
      issue(2'd1, 2'd2, 1'b1, 16'h8000, 16'h0000, 1'b0, 19);
      chk("err_zero_clear", {31'd0, err_zero}, 32'd0);
      wait_done();

      // Non-exact quotient
      @(negedge clk);
      issue(2'd2, 2'd1, 1'b1, 16'h4CCC, 16'h3334, 1'b0, 19);
      wait_done();

      // Back-to-back: second start issued in the done cycle
      @(negedge clk);
      issue(2'd0, 2'd0, 1'b1, 16'h68B9, 16'h1747, 1'b0, 19);
      wait_done();
      issue(2'd1, 2'd3, 1'b1, 16'h68B9, 16'h1747, 1'b1, 3);
      wait_done();

      // init_load beats start, with saturation
      @(negedge clk);
      init_load = 1'b1; init_b0 = 16'h9000; start = 1'b1; action = 2'd0; observation = 2'd0;
      @(posedge clk); #1;
      init_load = 1'b0; start = 1'b0;
      chk("init_sat", {belief[1], belief[0]}, 32'h0000_8000);
      chk("init_busy", {31'd0, busy}, 32'd0);
      repeat (25) @(negedge clk);
      chk("init_busy_later", {31'd0, busy}, 32'd0);

      // Reset in the middle of DIVIDE
      issue(2'd2, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 0);
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_belief", {belief[1], belief[0]}, 32'h4000_4000);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'd0, 2'd0, 1'b1, 16'h6000, 16'h2000, 1'b0, 19);
      wait_done();

      repeat (5) @(negedge clk);
      chk("queue_empty", expq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
